// File: rtl/elevator_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : elevator_pkg
//  Description : Shared defaults and encodings for the elevator request queue.
//  Revision    : 1.0 - initial release
// ============================================================================
package elevator_pkg;

    localparam int FLOOR_DEFAULT           = 6;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;

    // Controller travel state as presented on the direction port
    typedef enum logic [1:0] {
        DIR_STOP    = 2'd0,
        DIR_UP      = 2'd1,
        DIR_DOWN    = 2'd2,
        DIR_ILLEGAL = 2'd3
    } dir_t;

    // Service FSM: CLEAR is the single cycle in which the current floor is served
    typedef enum logic [1:0] {
        SVC_IDLE  = 2'd0,
        SVC_CLEAR = 2'd1,
        SVC_HOLD  = 2'd2
    } svc_state_t;

endpackage : elevator_pkg
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : button_debounce
//  Description : One-bit 2-flop synchronizer plus two-tick sample history.
//                press pulses on the tick that sees 0,1,1 across three ticks.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_debounce (
    input  logic clock,
    input  logic reset_n,
    input  logic tick,
    input  logic btn_raw,
    output logic press
);

    logic       r_sync_meta;
    logic       r_sync;
    logic [1:0] r_hist;     // [0] = previous tick sample, [1] = the one before

    // Bring the raw asynchronous level into the clock domain
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync_meta <= 1'b0;
            r_sync      <= 1'b0;
        end else begin
            r_sync_meta <= btn_raw;
            r_sync      <= r_sync_meta;
        end
    end

    // Record the synchronized level on every sample tick
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_hist <= 2'b00;
        end else if (tick) begin
            r_hist <= {r_hist[0], r_sync};
        end
    end

    // Rising edge confirmed on two consecutive ticks; holding never re-fires
    assign press = tick & r_sync & r_hist[0] & ~r_hist[1];

endmodule : button_debounce
`default_nettype wire

// File: rtl/elevator_request_queue.sv
`default_nettype none
// ============================================================================
//  Module      : elevator_request_queue
//  Description : Debounces hall/car buttons into pending-request registers and
//                clears the served floor when the controller opens the door.
//  Revision    : 1.0 - initial release
// ============================================================================
module elevator_request_queue
    import elevator_pkg::*;
#(
    parameter int FLOOR           = FLOOR_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [FLOOR-1:0] btn_up,
    input  logic [FLOOR-1:0] btn_down,
    input  logic [FLOOR-1:0] btn_inside,
    input  logic [FLOOR-1:0] currentFloor,
    input  logic             door_open,
    input  logic [1:0]       direction,
    output logic [FLOOR-1:0] queueUp,
    output logic [FLOOR-1:0] queueDown,
    output logic [FLOOR-1:0] queueinside,
    output logic             pos_err
);

    localparam int                 c_CNT_W      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST   = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    // Top floor has no up call, bottom floor has no down call
    localparam logic [FLOOR-1:0]   c_UP_VALID   = ~(FLOOR'(1) << (FLOOR - 1));
    localparam logic [FLOOR-1:0]   c_DOWN_VALID = ~FLOOR'(1);

    logic [c_CNT_W-1:0]   r_tick_cnt;
    logic                 w_tick;
    logic [3*FLOOR-1:0]   w_raw;
    logic [3*FLOOR-1:0]   w_press;
    logic [FLOOR-1:0]     w_set_up;
    logic [FLOOR-1:0]     w_set_dn;
    logic [FLOOR-1:0]     w_set_in;
    logic [FLOOR-1:0]     w_mask_up;
    logic [FLOOR-1:0]     w_mask_dn;
    logic [FLOOR-1:0]     w_mask_in;
    logic [FLOOR-1:0]     w_clr_up;
    logic [FLOOR-1:0]     w_clr_dn;
    logic [FLOOR-1:0]     w_clr_in;
    logic                 w_pos_ok;
    logic                 w_in_service;
    logic                 w_clearing;
    logic                 w_serve_up;
    logic                 w_serve_dn;
    svc_state_t           r_state;
    logic [FLOOR-1:0]     r_queue_up;
    logic [FLOOR-1:0]     r_queue_dn;
    logic [FLOOR-1:0]     r_queue_in;
    logic                 r_pos_err;

    // Free-running sample-tick counter shared by every debouncer
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_tick_cnt <= '0;
        end else if (r_tick_cnt == c_CNT_LAST) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    assign w_tick = (r_tick_cnt == c_CNT_LAST);

    // Bit layout: [FLOOR-1:0] up, [2F-1:F] down, [3F-1:2F] inside
    assign w_raw = {btn_inside, btn_down, btn_up};

    generate
        for (genvar gi = 0; gi < 3 * FLOOR; gi++) begin : g_debounce
            button_debounce u_debounce (
                .clock   (clock),
                .reset_n (reset_n),
                .tick    (w_tick),
                .btn_raw (w_raw[gi]),
                .press   (w_press[gi])
            );
        end
    endgenerate

    assign w_set_up = w_press[FLOOR-1:0]         & c_UP_VALID;
    assign w_set_dn = w_press[2*FLOOR-1:FLOOR]   & c_DOWN_VALID;
    assign w_set_in = w_press[3*FLOOR-1:2*FLOOR];

    // Service masks: which queues the current floor/direction serves. An
    // illegal direction serves only the car panel; a bad position serves none.
    assign w_pos_ok     = $onehot(currentFloor);
    assign w_in_service = (r_state == SVC_CLEAR) || (r_state == SVC_HOLD);
    assign w_clearing   = (r_state == SVC_CLEAR);
    assign w_serve_up   = (direction == DIR_STOP) || (direction == DIR_UP);
    assign w_serve_dn   = (direction == DIR_STOP) || (direction == DIR_DOWN);

    assign w_mask_in = (w_in_service && w_pos_ok)               ? currentFloor : '0;
    assign w_mask_up = (w_in_service && w_pos_ok && w_serve_up) ? currentFloor : '0;
    assign w_mask_dn = (w_in_service && w_pos_ok && w_serve_dn) ? currentFloor : '0;

    assign w_clr_in = w_clearing ? w_mask_in : '0;
    assign w_clr_up = w_clearing ? w_mask_up : '0;
    assign w_clr_dn = w_clearing ? w_mask_dn : '0;

    // Service FSM: one CLEAR cycle per door opening, then HOLD until it closes
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= SVC_IDLE;
        end else begin
            case (r_state)
                SVC_IDLE:  if (door_open)  r_state <= SVC_CLEAR;
                SVC_CLEAR: r_state <= SVC_HOLD;
                SVC_HOLD:  if (!door_open) r_state <= SVC_IDLE;
                default:   r_state <= SVC_IDLE;
            endcase
        end
    end

    // Pending requests: presses at a floor being served are dropped, clear wins
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_queue_up <= '0;
            r_queue_dn <= '0;
            r_queue_in <= '0;
        end else begin
            r_queue_up <= (r_queue_up | (w_set_up & ~w_mask_up)) & ~w_clr_up;
            r_queue_dn <= (r_queue_dn | (w_set_dn & ~w_mask_dn)) & ~w_clr_dn;
            r_queue_in <= (r_queue_in | (w_set_in & ~w_mask_in)) & ~w_clr_in;
        end
    end

    // Sticky position error, captured only when a floor is actually served
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pos_err <= 1'b0;
        end else if (w_clearing && !w_pos_ok) begin
            r_pos_err <= 1'b1;
        end
    end

    assign queueUp     = r_queue_up;
    assign queueDown   = r_queue_dn;
    assign queueinside = r_queue_in;
    assign pos_err     = r_pos_err;

endmodule : elevator_request_queue
`default_nettype wire

// File: doc/elevator_request_queue.md
ELEVATOR_REQUEST_QUEUE -- requirements
Module: elevator_request_queue

Interface
REQ-001 SHALL have parameter FLOOR, default 6, meaning number of floors and width of every floor vector.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 50000, meaning clock cycles between debounce sample ticks; legal range 2 to 2^20.
REQ-003 SHALL have port clock, input, 1 bit, sole clock, all logic on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port btn_up, input, FLOOR bits, raw asynchronous hall-up button levels, bit i means floor i+1.
REQ-006 SHALL have port btn_down, input, FLOOR bits, raw asynchronous hall-down button levels.
REQ-007 SHALL have port btn_inside, input, FLOOR bits, raw asynchronous car-panel button levels.
REQ-008 SHALL have port currentFloor, input, FLOOR bits, one-hot car position from the controller.
REQ-009 SHALL have port door_open, input, 1 bit, controller door-open level, synchronous to clock.
REQ-010 SHALL have port direction, input, 2 bits, controller travel state: 0 stop, 1 up, 2 down, 3 illegal.
REQ-011 SHALL have ports queueUp, queueDown and queueinside, outputs, FLOOR bits each, registered pending requests feeding the controller.
REQ-012 SHALL have port pos_err, output, 1 bit, sticky flag for a non-one-hot currentFloor sampled at a service event.

Function
REQ-013 SHALL pass each raw button bit through a 2-flop synchronizer before any other use.
REQ-014 SHALL generate one shared sample tick, a single-cycle pulse every DEBOUNCE_CYCLES clocks, from a free-running counter that wraps from DEBOUNCE_CYCLES-1 to 0.
REQ-015 SHALL accept a press on the tick where the synchronized bit is 1 on two consecutive ticks and was 0 on the tick before them; holding a button produces exactly one press.
REQ-016 SHALL set the corresponding queue bit on the clock edge after the accepting tick; a set bit stays set until cleared.
REQ-017 SHALL force btn_up bit FLOOR-1 and btn_down bit 0 to never set, because the top floor has no up call and the bottom floor has no down call.
REQ-018 SHALL run a service FSM with states IDLE, CLEAR and HOLD.
REQ-019 In IDLE, door_open=1 SHALL move the FSM to CLEAR; otherwise it stays in IDLE.
REQ-020 CLEAR SHALL last exactly one cycle.
REQ-021 In CLEAR, the block SHALL clear the queueinside bit at currentFloor; direction 0 clears both the up and down bits, direction 1 clears the up bit and direction 2 clears the down bit.
REQ-022 CLEAR SHALL always be followed by HOLD.
REQ-023 HOLD SHALL return to IDLE on door_open=0.
REQ-024 In CLEAR or HOLD, a press accepted at currentFloor SHALL be discarded for any queue that REQ-021 clears in the current direction; other presses are accepted normally.
REQ-025 When a set and a clear hit the same bit in the same cycle, the clear SHALL win.
REQ-026 direction=3 in CLEAR SHALL clear only the queueinside bit.
REQ-027 A non-one-hot currentFloor in CLEAR, including zero, SHALL clear nothing and set pos_err, which holds until reset.
REQ-028 Each queue output SHALL be a direct register output, with no combinational path from any input.

Reset
REQ-029 While reset_n=0, queueUp, queueDown, queueinside and pos_err SHALL read 0.
REQ-030 While reset_n=0, the FSM SHALL be in IDLE and the tick counter, synchronizers and debounce history SHALL all be 0.
REQ-031 If reset asserts mid-debounce or in HOLD, all partial state SHALL be discarded.
REQ-032 After reset, a button already held SHALL register once, per REQ-015.

Structure
REQ-033 Shared package elevator_pkg SHALL hold the FLOOR default, the direction encoding (DIR_STOP=0, DIR_UP=1, DIR_DOWN=2), the service FSM state encoding and the DEBOUNCE_CYCLES default.
REQ-034 Sub-module button_debounce (synchronizer plus two-tick history, one bit) SHALL be instantiated 3*FLOOR times via generate; the tick counter and FSM SHALL stay in the top level.

Verification (FLOOR=6, DEBOUNCE_CYCLES=4)
REQ-035 Hold btn_inside[3] for 20 cycles -> queueinside=6'b001000, set within 2+12 cycles of the press, with no second set while held.
REQ-036 Apply a 3-cycle glitch on btn_up[1] -> queueUp stays 0.
REQ-037 Pending queueUp=6'b000100 and queueDown=6'b000100; currentFloor=6'b000100, direction=1, door_open=1 for 10 cycles -> queueUp=0 one cycle after CLEAR, queueDown stays 6'b000100, exactly one CLEAR.
REQ-038 With the FSM in HOLD at floor 3 going up, press btn_up[2] -> ignored; press btn_down[2] -> queueDown bit 2 is set.
REQ-039 Press btn_up[5] and btn_down[0] -> both queues stay 0.
REQ-040 currentFloor=6'b000110 with door_open=1 -> no bits clear and pos_err=1; then reset_n=0 mid-HOLD -> all outputs 0 asynchronously.
